// File: rtl/snd_pkg.sv
// Shared types and helpers for the expansion-audio I2S transmitter.
// Holds the PCM word type, frame geometry and the level-to-PCM mapping.
package snd_pkg;

   localparam int PCM_W      = 16;
   localparam int FRAME_BCLK = 64;

   typedef logic [PCM_W-1:0] pcm_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } tx_state_e;

   // Unsigned 7-bit level becomes offset-binary, then flipping the MSB yields two's complement.
   function automatic pcm_t lvl2pcm(input logic [6:0] lvl);
      return {lvl, 9'b0} ^ 16'h8000;
   endfunction

endpackage

// File: rtl/snd_i2s_tx_if.sv
// Sound-input and I2S-output bundle of the transmitter.
// Fire-and-forget strobe in, free-running serial link out; there is no backpressure.
interface snd_i2s_tx_if;
   import snd_pkg::*;

   logic [6:0] snd_in;
   logic       snd_stb;
   logic       mute;
   logic       i2s_bclk;
   logic       i2s_lrck;
   logic       i2s_sdat;
   logic       frame_stb;
   logic       underrun;

   modport master (
      output snd_in, snd_stb, mute,
      input  i2s_bclk, i2s_lrck, i2s_sdat, frame_stb, underrun
   );

   modport slave (
      input  snd_in, snd_stb, mute,
      output i2s_bclk, i2s_lrck, i2s_sdat, frame_stb, underrun
   );

endinterface

// File: rtl/snd_avg.sv
// Box-car averager over 2^AVG_LOG2 strobes with a one-deep hold register.
// Result valid one clk after the window-closing strobe; a newer window overwrites an unread one.
module snd_avg
   import snd_pkg::*;
#(
   parameter int AVG_LOG2 = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] snd_in_i,
   input  logic       snd_stb_i,
   input  logic       hold_clr_i,
   output logic [6:0] hold_o,
   output logic       hold_vld_o
);

   localparam int ACC_W = 7 + AVG_LOG2;
   localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

   logic [ACC_W-1:0] acc_q, acc_d, sum;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [6:0]       hold_q, hold_d;
   logic             hold_vld_q, hold_vld_d;

   always_comb begin
      sum        = acc_q + ACC_W'(snd_in_i);
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      if (hold_clr_i) begin
         hold_vld_d = 1'b0;
      end
      // A window closing in the same clk as a read leaves the new value pending.
      if (snd_stb_i) begin
         if (cnt_q == CNT_LAST) begin
            acc_d      = '0;
            cnt_d      = '0;
            hold_d     = sum[ACC_W-1 -: 7];
            hold_vld_d = 1'b1;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q      <= '0;
         cnt_q      <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
      end
   end

   assign hold_o     = hold_q;
   assign hold_vld_o = hold_vld_q;

endmodule

// File: rtl/snd_i2s_tx.sv
// Averages the expansion-audio level and sends it as 16-bit PCM on both channels of a 64-BCLK I2S frame.
// New words enter at the next frame boundary; a missing word repeats the previous one and sets sticky underrun.
module snd_i2s_tx
   import snd_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int AVG_LOG2 = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   snd_i2s_tx_if.slave  tx_if
);

   localparam int BIT_W = $clog2(FRAME_BCLK);
   localparam int DIV_W = 8;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   tx_state_e        state_q;
   logic [DIV_W-1:0] div_q;
   logic [BIT_W-1:0] per_q, per_d;
   logic             bclk_q, lrck_q, sdat_q, sdat_d;
   logic             frame_stb_q, underrun_q;
   pcm_t             shift_word_q;

   logic             div_wrap, bclk_fall, load;
   logic [4:0]       slot;
   logic [6:0]       hold;
   logic             hold_vld;

   snd_avg #(
      .AVG_LOG2 (AVG_LOG2)
   ) u_avg (
      .clk        (clk),
      .rst_n      (rst_n),
      .snd_in_i   (tx_if.snd_in),
      .snd_stb_i  (tx_if.snd_stb),
      .hold_clr_i (load),
      .hold_o     (hold),
      .hold_vld_o (hold_vld)
   );

   assign div_wrap  = (state_q == ST_RUN) && (div_q == DIV_LAST);
   assign bclk_fall = div_wrap && bclk_q;
   // per_q resets to the last period so the first fall wraps into period 0 and loads a word.
   assign per_d     = per_q + BIT_W'(1);
   assign load      = bclk_fall && (per_d == '0);
   assign slot      = per_d[4:0];

   // One BCLK of I2S delay after each lrck edge, MSB first, zero padding for the rest of the half.
   always_comb begin
      sdat_d = 1'b0;
      if ((slot != 5'd0) && (slot <= 5'd16)) begin
         sdat_d = shift_word_q[4'(5'd16 - slot)];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         div_q        <= '0;
         per_q        <= '1;
         bclk_q       <= 1'b1;
         lrck_q       <= 1'b0;
         sdat_q       <= 1'b0;
         frame_stb_q  <= 1'b0;
         underrun_q   <= 1'b0;
         shift_word_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_q <= ST_RUN;
               div_q   <= '0;
            end
            ST_RUN: begin
               frame_stb_q <= load;
               div_q       <= div_wrap ? '0 : div_q + DIV_W'(1);
               if (div_wrap) begin
                  bclk_q <= ~bclk_q;
               end
               if (bclk_fall) begin
                  per_q  <= per_d;
                  lrck_q <= per_d[BIT_W-1];
                  sdat_q <= sdat_d;
               end
               if (load) begin
                  if (tx_if.mute) begin
                     shift_word_q <= '0;
                  end else if (hold_vld) begin
                     shift_word_q <= lvl2pcm(hold);
                  end else begin
                     underrun_q <= 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign tx_if.i2s_bclk  = bclk_q;
   assign tx_if.i2s_lrck  = lrck_q;
   assign tx_if.i2s_sdat  = sdat_q;
   assign tx_if.frame_stb = frame_stb_q;
   assign tx_if.underrun  = underrun_q;

endmodule
